// File: rtl/uart64_pkg.sv
// Shared definitions for the 64-bit UART link: state encodings,
// word geometry and the bit-timing helper.
package uart64_pkg;

  localparam int BYTES_PER_WORD  = 8;
  localparam int RX_TIMEOUT_BITS = 20;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Clocks per bit with integer truncation.
  function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart64_link_rx.sv
// Byte-level 8N1 receiver: 2-FF synchroniser, falling-edge start detect,
// half-bit start confirmation, mid-bit data sampling and stop-bit check.
// o_valid / o_frame_err are single-cycle pulses; o_byte is stable from the
// o_valid pulse until the next valid byte. There is no back-pressure.
module uart_byte_rx
  import uart64_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rxd,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_frame_err,
  output rx_state_t  o_state
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_prev;
  rx_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      r_byte;
  logic            r_valid;
  logic            r_ferr;
  logic            w_fall;

  // Synchronise the line (idle high) and keep one more stage for edge detect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_fall = r_prev & ~r_sync2;

  // Receive FSM: confirm start at half bit, then sample every full bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_cnt <= '0;
          if (w_fall) r_state <= RX_START;
        end
        RX_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt <= '0;
            r_bit <= '0;
            // A line already back high is a glitch, not a start bit.
            r_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_shift <= {r_sync2, r_shift[7:1]};
            if (r_bit == 3'd7) r_state <= RX_STOP;
            else               r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (r_cnt == FULL_LAST) begin
            r_cnt   <= '0;
            r_state <= RX_IDLE;
            if (r_sync2) begin
              r_byte  <= r_shift;
              r_valid <= 1'b1;
            end else begin
              r_ferr <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  assign o_byte      = r_byte;
  assign o_valid     = r_valid;
  assign o_frame_err = r_ferr;
  assign o_state     = r_state;

endmodule

// File: rtl/uart64_link.sv
// 64-bit word <-> 8-byte 8N1 UART link. TX sends byte 0 (bits 7:0) first,
// bytes back-to-back; RX reassembles eight valid bytes into one word.
module uart64_link
  import uart64_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] data_in_64,
  input  logic        manual_start,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic [63:0] data_out_64,
  output logic        data_out_done
);

  localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int TIMEOUT_CLKS = RX_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] FULL_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CLKS);
  localparam logic [2:0]    LAST_BYTE    = 3'(BYTES_PER_WORD - 1);

  // rst_n keeps its historical name but is an active-high reset.
  logic w_rst;
  assign w_rst = rst_n;

  logic          r_start_prev;
  logic [63:0]   r_data_prev;
  logic          r_pending;
  logic          w_req;

  tx_state_t     r_tx_state;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic [2:0]    r_tx_byte;
  logic [63:0]   r_tx_shift;
  logic          r_txd;
  logic          w_tx_bit_end;

  logic [7:0]    w_rx_byte;
  logic          w_rx_valid;
  logic          w_rx_ferr;
  rx_state_t     w_rx_state;
  logic [63:0]   r_asm;
  logic [2:0]    r_rx_k;
  logic [TW-1:0] r_idle_cnt;
  logic [63:0]   r_dout;
  logic          r_done;

  assign w_req = (manual_start & ~r_start_prev) | (data_in_64 != r_data_prev);

  // Request detection: a new event always wins over the IDLE hand-off so
  // requests arriving mid-frame collapse into one pending transmission.
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_start_prev <= 1'b0;
      r_data_prev  <= '0;
      r_pending    <= 1'b0;
    end else begin
      r_start_prev <= manual_start;
      r_data_prev  <= data_in_64;
      if (w_req)                      r_pending <= 1'b1;
      else if (r_tx_state == TX_IDLE) r_pending <= 1'b0;
    end
  end

  assign w_tx_bit_end = (r_tx_cnt == FULL_LAST);

  // TX FSM: START, 8 DATA bits LSB-first, STOP, repeated for all 8 bytes.
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_byte  <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          r_txd    <= 1'b1;
          r_tx_cnt <= '0;
          if (r_pending) begin
            r_tx_shift <= data_in_64;
            r_tx_byte  <= '0;
            r_txd      <= 1'b0;
            r_tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_state <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= {1'b0, r_tx_shift[63:1]};
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= TX_STOP;
            end else begin
              r_tx_bit <= r_tx_bit + 3'd1;
              r_txd    <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_byte == LAST_BYTE) begin
              r_tx_state <= TX_IDLE;
            end else begin
              r_tx_byte  <= r_tx_byte + 3'd1;
              r_txd      <= 1'b0;
              r_tx_state <= TX_START;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + CW'(1);
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign uart_txd = r_txd;

  uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (clk),
    .i_rst       (w_rst),
    .i_rxd       (uart_rxd),
    .o_byte      (w_rx_byte),
    .o_valid     (w_rx_valid),
    .o_frame_err (w_rx_ferr),
    .o_state     (w_rx_state)
  );

  // Word assembly, completion pulse, framing-error and idle-timeout resync.
  always_ff @(posedge clk or posedge w_rst) begin
    if (w_rst) begin
      r_asm      <= '0;
      r_rx_k     <= '0;
      r_idle_cnt <= '0;
      r_dout     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_rx_valid) begin
        r_idle_cnt <= '0;
        if (r_rx_k == LAST_BYTE) begin
          r_dout <= {w_rx_byte, r_asm[55:0]};
          r_done <= 1'b1;
          r_rx_k <= '0;
        end else begin
          r_asm[{r_rx_k, 3'b000} +: 8] <= w_rx_byte;
          r_rx_k <= r_rx_k + 3'd1;
        end
      end else if (w_rx_ferr) begin
        r_rx_k     <= '0;
        r_idle_cnt <= '0;
      end else if ((r_rx_k != 3'd0) && (w_rx_state == RX_IDLE)) begin
        if (r_idle_cnt == TIMEOUT_LAST) begin
          r_rx_k     <= '0;
          r_idle_cnt <= '0;
        end else begin
          r_idle_cnt <= r_idle_cnt + TW'(1);
        end
      end else begin
        r_idle_cnt <= '0;
      end
    end
  end

  assign data_out_64   = r_dout;
  assign data_out_done = r_done;

endmodule

// File: tb/tb_uart64_link.sv
// Bench for uart64_link, run at a reduced bit time (16 clocks per bit).
module tb_uart64_link;

  localparam int CLK_FREQ   = 1_600_000;
  localparam int BAUD       = 100_000;
  localparam int CPB        = CLK_FREQ / BAUD;
  localparam int FRAME_CLKS = 80 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data_in = '0;
  logic        manual_start = 1'b0;
  logic        ext_mode = 1'b0;
  logic        ext_line = 1'b1;
  logic        rxd;
  logic        txd;
  logic [63:0] dout;
  logic        done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [63:0] exp_q[$];

  assign rxd = ext_mode ? ext_line : txd;

  uart64_link #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst),
    .data_in_64    (data_in),
    .manual_start  (manual_start),
    .uart_rxd      (rxd),
    .uart_txd      (txd),
    .data_out_64   (dout),
    .data_out_done (done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      logic [63:0] e;
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got word %h, required no done pulse", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL done_word: got %h required %h", dout, e);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Expected line image of one 80-bit frame: per byte start 0, 8 data bits
  // LSB-first, stop 1; byte 0 first.
  function automatic logic [79:0] line_image(input logic [63:0] w);
    logic [79:0] img;
    int b;
    int p;
    for (int i = 0; i < 80; i++) begin
      b = i / 10;
      p = i % 10;
      if (p == 0)      img[i] = 1'b0;
      else if (p == 9) img[i] = 1'b1;
      else             img[i] = w[8*b + p - 1];
    end
    return img;
  endfunction

  // ---------------- driver / monitor tasks ----------------
  task automatic wait_tx_start(input int budget, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Entered at the first negedge with txd low; samples each bit mid-way.
  task automatic capture_frame(output logic [79:0] img);
    for (int i = 0; i < 80; i++) begin
      if (i == 0) repeat (CPB / 2) @(negedge clk);
      else        repeat (CPB) @(negedge clk);
      img[i] = txd;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    ext_line = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ext_line = b[i];
      repeat (CPB) @(negedge clk);
    end
    ext_line = stop;
    repeat (CPB) @(negedge clk);
    ext_line = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    ext_line = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int n = 0; n < budget && done_cnt < target; n++) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b required 1", txd); end
      checks++;
      if (dout !== 64'h0) begin errors++; $display("FAIL reset_dout: got %h required 0", dout); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b required 1", txd); end
  endtask

  task automatic test_single_loopback();
    logic [63:0] w = 64'h2d7e66091ed0a403;
    logic [79:0] img;
    logic [79:0] ref_img;
    int base = done_cnt;
    exp_q.push_back(w);
    data_in = w;
    manual_start = 1'b1;
    @(negedge clk);
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL start_too_early: got %b required 1", txd); end
    @(negedge clk);
    manual_start = 1'b0;
    checks++;
    if (txd !== 1'b0) begin errors++; $display("FAIL start_latency: got %b required 0", txd); end
    capture_frame(img);
    checks++;
    if (img[8:1] !== 8'h03) begin errors++; $display("FAIL first_byte: got %h required 03", img[8:1]); end
    ref_img = line_image(w);
    checks++;
    if (img !== ref_img) begin errors++; $display("FAIL single_frame: got %h required %h", img, ref_img); end
    wait_done(base + 1, 4 * CPB);
    checks++;
    if (done_cnt !== base + 1) begin errors++; $display("FAIL single_done: got %0d pulses required %0d", done_cnt - base, 1); end
    repeat (3 * CPB) @(negedge clk);
    checks++;
    if (dout !== w) begin errors++; $display("FAIL dout_hold: got %h required %h", dout, w); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] w0 = {$urandom, $urandom};
    logic [63:0] w2 = 64'hd253328dd2c0fc3c;
    logic [63:0] w3 = 64'h8162476652bdd1d0;
    logic [63:0] words[3];
    logic [79:0] img;
    logic [79:0] ref_img;
    logic ok;
    logic quiet;
    int base = done_cnt;
    if (w0 == data_in) w0 = ~w0;
    words[0] = w0; words[1] = w2; words[2] = w3;
    for (int i = 0; i < 3; i++) exp_q.push_back(words[i]);
    data_in = w0;
    wait_tx_start(4, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL b2b_start: got no start required start"); end
    for (int f = 0; f < 3; f++) begin
      fork
        capture_frame(img);
        begin
          if (f == 0) begin repeat (FRAME_CLKS / 10) @(negedge clk); data_in = w2; end
          if (f == 1) begin repeat (FRAME_CLKS / 2) @(negedge clk); data_in = w3; end
        end
      join
      ref_img = line_image(words[f]);
      checks++;
      if (img !== ref_img) begin errors++; $display("FAIL b2b_frame%0d: got %h required %h", f, img, ref_img); end
      if (f < 2) begin
        repeat (CPB / 2) @(negedge clk);
        checks++;
        if (txd !== 1'b1) begin errors++; $display("FAIL b2b_stop_tail%0d: got %b required 1", f, txd); end
        @(negedge clk);
        checks++;
        if (txd !== 1'b0) begin errors++; $display("FAIL b2b_next_start%0d: got %b required 0", f, txd); end
      end
    end
    wait_done(base + 3, 4 * CPB);
    quiet = 1'b1;
    repeat (4 * CPB) begin
      @(negedge clk);
      if (txd !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (done_cnt !== base + 3) begin errors++; $display("FAIL b2b_done_count: got %0d required 3", done_cnt - base); end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL b2b_idle_after: got activity required idle high"); end
  endtask

  task automatic test_no_double_queue();
    logic [63:0] wa = {$urandom, $urandom};
    logic [63:0] wx = {$urandom, $urandom};
    logic [63:0] wb = {$urandom, $urandom};
    logic [79:0] img;
    logic [79:0] ref_img;
    logic ok;
    logic quiet;
    int base = done_cnt;
    if (wa == data_in) wa = ~wa;
    if (wb == wx) wb = ~wx;
    exp_q.push_back(wa);
    exp_q.push_back(wb);
    data_in = wa;
    wait_tx_start(4, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ndq_start: got no start required start"); end
    fork
      capture_frame(img);
      begin
        repeat (100) @(negedge clk); data_in = wx;
        repeat (100) @(negedge clk); data_in = wb;
        repeat (100) @(negedge clk); manual_start = 1'b1;
        repeat (2) @(negedge clk);   manual_start = 1'b0;
      end
    join
    ref_img = line_image(wa);
    checks++;
    if (img !== ref_img) begin errors++; $display("FAIL ndq_frame_a: got %h required %h", img, ref_img); end
    wait_tx_start(CPB, ok);
    capture_frame(img);
    ref_img = line_image(wb);
    checks++;
    if (img !== ref_img) begin errors++; $display("FAIL ndq_frame_b: got %h required %h", img, ref_img); end
    quiet = 1'b1;
    repeat (4 * CPB) begin
      @(negedge clk);
      if (txd !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL ndq_extra_frame: got activity required idle high"); end
    checks++;
    if (done_cnt !== base + 2) begin errors++; $display("FAIL ndq_done_count: got %0d required 2", done_cnt - base); end
  endtask

  task automatic test_random_loopback();
    logic [63:0] w;
    logic [79:0] img;
    logic [79:0] ref_img;
    logic ok;
    int base;
    for (int it = 0; it < 3; it++) begin
      base = done_cnt;
      if (it == 1) begin
        w = data_in;
        manual_start = 1'b1;
      end else begin
        w = {$urandom, $urandom};
        if (w == data_in) w = ~w;
        data_in = w;
      end
      exp_q.push_back(w);
      wait_tx_start(4, ok);
      manual_start = 1'b0;
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL rand_start%0d: got no start required start", it); end
      capture_frame(img);
      ref_img = line_image(w);
      checks++;
      if (img !== ref_img) begin errors++; $display("FAIL rand_frame%0d: got %h required %h", it, img, ref_img); end
      wait_done(base + 1, 4 * CPB);
      checks++;
      if (done_cnt !== base + 1) begin errors++; $display("FAIL rand_done%0d: got %0d required 1", it, done_cnt - base); end
      repeat (2 * CPB) @(negedge clk);
    end
  endtask

  task automatic test_framing_error();
    logic [63:0] w = 64'h0123456789abcdef;
    int base = done_cnt;
    ext_line = 1'b1;
    ext_mode = 1'b1;
    idle_bits(2);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b0);
    idle_bits(2);
    checks++;
    if (done_cnt !== base) begin errors++; $display("FAIL ferr_no_done: got %0d required 0", done_cnt - base); end
    exp_q.push_back(w);
    for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8], 1'b1);
    idle_bits(2);
    checks++;
    if (done_cnt !== base + 1) begin errors++; $display("FAIL ferr_recover: got %0d required 1", done_cnt - base); end
    ext_mode = 1'b0;
  endtask

  task automatic test_glitch_timeout();
    logic [63:0] w = 64'hffffffff00000000;
    logic [63:0] wq = {$urandom, $urandom};
    int base = done_cnt;
    ext_line = 1'b1;
    ext_mode = 1'b1;
    idle_bits(2);
    ext_line = 1'b0;
    repeat (3) @(negedge clk);
    idle_bits(3);
    checks++;
    if (done_cnt !== base) begin errors++; $display("FAIL glitch_done: got %0d required 0", done_cnt - base); end
    for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    idle_bits(25);
    exp_q.push_back(w);
    for (int k = 0; k < 8; k++) send_byte(w[8*k +: 8], 1'b1);
    idle_bits(2);
    checks++;
    if (done_cnt !== base + 1) begin errors++; $display("FAIL timeout_resync: got %0d required 1", done_cnt - base); end
    exp_q.push_back(wq);
    for (int k = 0; k < 4; k++) send_byte(wq[8*k +: 8], 1'b1);
    idle_bits(15);
    for (int k = 4; k < 8; k++) send_byte(wq[8*k +: 8], 1'b1);
    idle_bits(2);
    checks++;
    if (done_cnt !== base + 2) begin errors++; $display("FAIL short_idle_keep: got %0d required 2", done_cnt - base); end
    ext_mode = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    logic quiet;
    int base = done_cnt;
    logic [63:0] w = {$urandom, $urandom};
    if (w == data_in) w = ~w;
    data_in = w;
    wait_tx_start(4, ok);
    repeat (10 * CPB + CPB / 2) @(negedge clk);
    checks++;
    if (txd !== 1'b0) begin errors++; $display("FAIL mid_start_bit: got %b required 0", txd); end
    rst = 1'b1;
    data_in = '0;
    #1;
    checks++;
    if (txd !== 1'b1) begin errors++; $display("FAIL abort_txd: got %b required 1", txd); end
    checks++;
    if (dout !== 64'h0) begin errors++; $display("FAIL abort_dout: got %h required 0", dout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (FRAME_CLKS / 4) begin
      @(negedge clk);
      if (txd !== 1'b1 || done !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL abort_quiet: got activity required idle"); end
    checks++;
    if (done_cnt !== base) begin errors++; $display("FAIL abort_done: got %0d required 0", done_cnt - base); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_loopback();
    test_back_to_back();
    test_no_double_queue();
    test_random_loopback();
    test_framing_error();
    test_glitch_timeout();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL words_outstanding: got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
